// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and writeback entry type for the register file write side
package regfile_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int ZERO_REG       = 0;

  typedef struct packed {
    logic [ADDR_W_DEFAULT-1:0] rd;
    logic [XLEN_DEFAULT-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_dual_push_fifo.sv
// rtl/wb_dual_push_fifo.sv - in-order FIFO taking up to two pushes and one pop per cycle
module wb_dual_push_fifo
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push0,
  input  logic [ADDR_W-1:0]          push0_rd,
  input  logic [XLEN-1:0]            push0_data,
  input  logic                       push1,
  input  logic [ADDR_W-1:0]          push1_rd,
  input  logic [XLEN-1:0]            push1_data,
  input  logic                       pop,
  output logic [ADDR_W-1:0]          head_rd,
  output logic [XLEN-1:0]            head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DEPTH-1:0]           entry_vld,
  output logic [DEPTH*ADDR_W-1:0]    entry_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_b, offset;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] rd_mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_mem_d [DEPTH];
  logic [XLEN-1:0]   data_mem_q [DEPTH];
  logic [XLEN-1:0]   data_mem_d [DEPTH];

  // push0 is the older entry; push1 lands directly behind it (or at the tail if push0 is idle)
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    wr_ptr_b   = wr_ptr_q + PTR_W'(push0);
    if (push0) begin
      rd_mem_d[wr_ptr_q]   = push0_rd;
      data_mem_d[wr_ptr_q] = push0_data;
    end
    if (push1) begin
      rd_mem_d[wr_ptr_b]   = push1_rd;
      data_mem_d[wr_ptr_b] = push1_data;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
  end

  always_comb begin
    offset    = '0;
    entry_vld = '0;
    entry_rd  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset                          = PTR_W'(i) - rd_ptr_q;
      entry_vld[i]                    = {1'b0, offset} < count_q;
      entry_rd[i*ADDR_W +: ADDR_W]    = rd_mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - merges ALU/LSU writebacks onto the single register file write port
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [ADDR_W-1:0]      lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  output logic [ADDR_W-1:0]      dest,
  output logic                   write_enable,
  output logic [XLEN-1:0]        data_in,
  input  logic [ADDR_W-1:0]      src_one,
  input  logic [ADDR_W-1:0]      src_two,
  output logic                   busy_one,
  output logic                   busy_two,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_REG);

  logic                    need_lsu, need_alu, lsu_enq, alu_enq, drain;
  logic [CNT_W-1:0]        free;
  logic [ADDR_W-1:0]       head_rd;
  logic [XLEN-1:0]         head_data;
  logic [DEPTH-1:0]        entry_vld;
  logic [DEPTH*ADDR_W-1:0] entry_rd;
  logic [ADDR_W-1:0]       dest_q, dest_d;
  logic [XLEN-1:0]         data_in_q, data_in_d;
  logic                    write_enable_q, write_enable_d;
  logic                    hit_one, hit_two;

  assign need_lsu = lsu_valid && (lsu_rd != ZERO);
  assign need_alu = alu_valid && (alu_rd != ZERO);
  assign drain    = (count != '0);
  // A slot freed by this cycle's drain is reusable now; the LSU gets first claim on it
  assign free      = CNT_W'(DEPTH) - count + CNT_W'(drain);
  assign lsu_ready = (lsu_rd == ZERO) || (free >= CNT_W'(1));
  assign alu_ready = (alu_rd == ZERO) || (free >= (CNT_W'(1) + CNT_W'(need_lsu)));
  assign lsu_enq   = need_lsu && lsu_ready;
  assign alu_enq   = need_alu && alu_ready;

  wb_dual_push_fifo #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push0      (lsu_enq),
    .push0_rd   (lsu_rd),
    .push0_data (lsu_data),
    .push1      (alu_enq),
    .push1_rd   (alu_rd),
    .push1_data (alu_data),
    .pop        (drain),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .count      (count),
    .entry_vld  (entry_vld),
    .entry_rd   (entry_rd)
  );

  always_comb begin
    write_enable_d = drain;
    dest_d         = drain ? head_rd : dest_q;
    data_in_d      = drain ? head_data : data_in_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable_q <= 1'b0;
      dest_q         <= '0;
      data_in_q      <= '0;
    end else begin
      write_enable_q <= write_enable_d;
      dest_q         <= dest_d;
      data_in_q      <= data_in_d;
    end
  end

  // Pending writes: anything still queued, plus the write sitting on the port this cycle
  always_comb begin
    hit_one = write_enable_q && (dest_q == src_one);
    hit_two = write_enable_q && (dest_q == src_two);
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entry_rd[i*ADDR_W +: ADDR_W] == src_one)) hit_one = 1'b1;
      if (entry_vld[i] && (entry_rd[i*ADDR_W +: ADDR_W] == src_two)) hit_two = 1'b1;
    end
  end

  assign busy_one     = (src_one != ZERO) && hit_one;
  assign busy_two     = (src_two != ZERO) && hit_two;
  assign dest         = dest_q;
  assign write_enable = write_enable_q;
  assign data_in      = data_in_q;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - scoreboard bench for regfile_writeback_queue
module tb_regfile_writeback_queue;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, dest, src_one, src_two;
  logic [31:0] alu_data, lsu_data, data_in;
  logic        write_enable, busy_one, busy_two;
  logic [2:0]  count;

  int vectors = 0;
  int miscompares = 0;
  wb_entry_t sb[$];

  always #5 clk = ~clk;

  regfile_writeback_queue dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .dest         (dest),
    .write_enable (write_enable),
    .data_in      (data_in),
    .src_one      (src_one),
    .src_two      (src_two),
    .busy_one     (busy_one),
    .busy_two     (busy_two),
    .count        (count)
  );

  // Register file port monitor: every write must match the oldest expected entry
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write dest=%0d data=%h, none expected", dest, data_in);
      end else begin
        wb_entry_t e;
        e = sb.pop_front();
        if (dest !== e.rd || data_in !== e.data) begin
          miscompares++;
          $display("FAIL write_order got dest=%0d data=%h exp dest=%0d data=%h", dest, data_in, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic drive_cycle(input logic lv, input logic [4:0] lrd, input logic [31:0] ld, input logic exp_lr,
                             input logic av, input logic [4:0] ard, input logic [31:0] ad, input logic exp_ar);
    @(negedge clk);
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    #1;
    if (lv && exp_lr && lrd != 5'd0) sb.push_back('{rd: lrd, data: ld});
    if (av && exp_ar && ard != 5'd0) sb.push_back('{rd: ard, data: ad});
  endtask

  task automatic idle();
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    src_one = 5'd5; src_two = 5'd3;
    idle(); idle();
    reset = 1'b0;
    idle();
    vectors++;
    if (write_enable !== 1'b0 || dest !== 5'd0 || data_in !== 32'd0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state got we=%b dest=%0d data=%h count=%0d exp 0/0/0/0", write_enable, dest, data_in, count);
    end
    vectors++;
    if (busy_one !== 1'b0 || busy_two !== 1'b0 || alu_ready !== 1'b1 || lsu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_flags got busy=%b%b rdy=%b%b exp busy=00 rdy=11", busy_one, busy_two, lsu_ready, alu_ready);
    end
  endtask

  task automatic test_single_alu();
    src_one = 5'd5;
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    vectors++;
    if (alu_ready !== 1'b1 || busy_one !== 1'b0) begin
      miscompares++;
      $display("FAIL single_accept got ready=%b busy=%b exp ready=1 busy=0", alu_ready, busy_one);
    end
    idle();
    vectors++;
    if (count !== 3'd1 || write_enable !== 1'b0 || busy_one !== 1'b1) begin
      miscompares++;
      $display("FAIL single_n1 got count=%0d we=%b busy=%b exp 1/0/1", count, write_enable, busy_one);
    end
    idle();
    vectors++;
    if (write_enable !== 1'b1 || busy_one !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL single_n2 got we=%b busy=%b count=%0d exp 1/1/0", write_enable, busy_one, count);
    end
    idle();
    vectors++;
    if (write_enable !== 1'b0 || busy_one !== 1'b0) begin
      miscompares++;
      $display("FAIL single_n3 got we=%b busy=%b exp 0/0", write_enable, busy_one);
    end
  endtask

  task automatic test_dual_accept();
    drive_cycle(1'b1, 5'd3, 32'h11, 1'b1, 1'b1, 5'd4, 32'h22, 1'b1);
    vectors++;
    if (lsu_ready !== 1'b1 || alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL dual_ready got lsu=%b alu=%b exp 1/1", lsu_ready, alu_ready);
    end
    idle();
    vectors++;
    if (count !== 3'd2) begin
      miscompares++;
      $display("FAIL dual_peak got count=%0d exp 2", count);
    end
    idle(); idle(); idle();
    vectors++;
    if (count !== 3'd0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL dual_drained got count=%0d pending=%0d exp 0/0", count, sb.size());
    end
  endtask

  task automatic test_zero_reg();
    src_one = 5'd0;
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd0, 32'hFFFF, 1'b1);
    vectors++;
    if (alu_ready !== 1'b1 || busy_one !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_accept got ready=%b busy=%b exp 1/0", alu_ready, busy_one);
    end
    for (int i = 0; i < 2; i++) begin
      idle();
      vectors++;
      if (count !== 3'd0 || write_enable !== 1'b0 || busy_one !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_discard got count=%0d we=%b busy=%b exp 0/0/0", count, write_enable, busy_one);
      end
    end
  endtask

  task automatic test_full_priority();
    drive_cycle(1'b1, 5'd8,  32'h8,  1'b1, 1'b1, 5'd9,  32'h9,  1'b1);
    drive_cycle(1'b1, 5'd10, 32'h10, 1'b1, 1'b1, 5'd11, 32'h11, 1'b1);
    vectors++;
    if (count !== 3'd2 || alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_2 got count=%0d alu_ready=%b exp 2/1", count, alu_ready);
    end
    drive_cycle(1'b1, 5'd12, 32'h12, 1'b1, 1'b1, 5'd13, 32'h13, 1'b1);
    vectors++;
    if (count !== 3'd3 || alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_3 got count=%0d alu_ready=%b exp 3/1", count, alu_ready);
    end
    drive_cycle(1'b1, 5'd14, 32'h14, 1'b1, 1'b1, 5'd15, 32'h15, 1'b0);
    vectors++;
    if (count !== 3'd4 || lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_prio got count=%0d lsu=%b alu=%b exp 4/1/0", count, lsu_ready, alu_ready);
    end
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd15, 32'h15, 1'b1);
    vectors++;
    if (count !== 3'd4 || alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_alu_retry got count=%0d alu=%b exp 4/1", count, alu_ready);
    end
    for (int i = 0; i < 6; i++) idle();
    vectors++;
    if (count !== 3'd0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL full_drained got count=%0d pending=%0d exp 0/0", count, sb.size());
    end
  endtask

  task automatic test_back_to_back();
    src_two = 5'd7;
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'hA, 1'b1);
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd7, 32'hB, 1'b1);
    idle();
    vectors++;
    if (write_enable !== 1'b1 || data_in !== 32'hA || busy_two !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first got we=%b data=%h busy=%b exp 1/a/1", write_enable, data_in, busy_two);
    end
    idle();
    vectors++;
    if (write_enable !== 1'b1 || data_in !== 32'hB || busy_two !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second got we=%b data=%h busy=%b exp 1/b/1", write_enable, data_in, busy_two);
    end
    idle();
    vectors++;
    if (write_enable !== 1'b0 || busy_two !== 1'b0 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_done got we=%b busy=%b pending=%0d exp 0/0/0", write_enable, busy_two, sb.size());
    end
  endtask

  task automatic test_reset_flush();
    src_one = 5'd21; src_two = 5'd22;
    drive_cycle(1'b1, 5'd20, 32'h20, 1'b1, 1'b1, 5'd21, 32'h21, 1'b1);
    drive_cycle(1'b1, 5'd22, 32'h22, 1'b1, 1'b1, 5'd23, 32'h23, 1'b1);
    idle();
    vectors++;
    if (count !== 3'd3 || write_enable !== 1'b1 || busy_one !== 1'b1 || busy_two !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_pre got count=%0d we=%b busy=%b%b exp 3/1/11", count, write_enable, busy_one, busy_two);
    end
    reset = 1'b1;
    sb.delete();
    @(negedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (count !== 3'd0 || write_enable !== 1'b0 || dest !== 5'd0 || data_in !== 32'd0) begin
      miscompares++;
      $display("FAIL flush_state got count=%0d we=%b dest=%0d data=%h exp 0/0/0/0", count, write_enable, dest, data_in);
    end
    vectors++;
    if (busy_one !== 1'b0 || busy_two !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_busy got busy=%b%b exp 00", busy_one, busy_two);
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      vectors++;
      if (write_enable !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_no_write got we=%b exp 0", write_enable);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    src_one = '0; src_two = '0;
    test_reset();
    test_single_alu();
    test_dual_accept();
    test_zero_reg();
    test_full_priority();
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
